// File: rtl/game_dialog_ctrl_if.sv
// Dialog controller bus: keyboard/tile/frame inputs and renderer/progress outputs.
// The slave modport is the controller; the master modport drives it.
interface game_dialog_ctrl_if;
  logic [3:0] key;
  logic [3:0] current_pix;
  logic       frame_tick;
  logic [3:0] page_sel;
  logic       busy;
  logic       item;
  logic       item2;
  logic       door;

  modport slave (
    input  key, current_pix, frame_tick,
    output page_sel, busy, item, item2, door
  );

  modport master (
    output key, current_pix, frame_tick,
    input  page_sel, busy, item, item2, door
  );
endinterface

// File: rtl/game_dialog_ctrl.sv
// NPC/door/chest dialog sequencer: prompt, accept, timed result page, cooldown.
// Tracks sticky item/item2/door progress flags; all outputs are registered.
module game_dialog_ctrl #(
  parameter logic [3:0] KEY_ACCEPT  = 4'h1,
  parameter logic [7:0] HOLD_FRAMES = 8'd120,
  parameter logic [7:0] COOL_FRAMES = 8'd30
) (
  input  logic               clk,
  input  logic               rst,
  game_dialog_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TALK, RESULT, COOLDOWN} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_key_p1;
  logic       r_rst_p1;
  logic [3:0] r_tile_q, w_tile_nxt;
  logic [3:0] r_res_page, w_res_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_item, r_item2, r_door;
  logic       w_set_item, w_set_item2, w_set_door;
  logic       w_accept, w_cnt_last;
  logic [3:0] w_page;
  logic [3:0] r_page_sel;
  logic       r_busy, r_item_o, r_item2_o, r_door_o;

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic is_tile(input logic [3:0] t);
    return (t == 4'd2) || (t == 4'd3) || (t == 4'd4) || (t == 4'd6);
  endfunction

  function automatic logic [3:0] prompt_page(input logic [3:0] t);
    case (t)
      4'd2:    return 4'd1;
      4'd3:    return 4'd2;
      4'd4:    return 4'd3;
      4'd6:    return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

  // Rising edge of the accept key; the cycle right after reset never counts as a press.
  assign w_accept   = (bus.key == KEY_ACCEPT) && (r_key_p1 != KEY_ACCEPT) && !r_rst_p1;
  assign w_cnt_last = bus.frame_tick && (r_cnt <= 8'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_tile_nxt  = r_tile_q;
    w_res_nxt   = r_res_page;
    w_cnt_nxt   = r_cnt;
    w_set_item  = 1'b0;
    w_set_item2 = 1'b0;
    w_set_door  = 1'b0;
    case (r_state)
      IDLE: begin
        if (is_tile(bus.current_pix)) begin
          w_tile_nxt  = bus.current_pix;
          w_state_nxt = TALK;
        end
      end
      TALK: begin
        if (bus.current_pix != r_tile_q) begin
          w_state_nxt = IDLE;
        end else if (w_accept) begin
          w_cnt_nxt   = HOLD_FRAMES;
          w_state_nxt = RESULT;
          case (r_tile_q)
            4'd2: w_res_nxt = 4'd5;
            4'd3: begin
              w_set_item = 1'b1;
              w_res_nxt  = 4'd6;
            end
            4'd4: begin
              w_set_door = r_item;
              w_res_nxt  = r_item ? 4'd7 : 4'd8;
            end
            4'd6: begin
              w_set_item2 = r_item;
              w_res_nxt   = r_item ? 4'd9 : 4'd8;
            end
            default: w_res_nxt = 4'd0;
          endcase
        end
      end
      RESULT: begin
        if (w_accept || w_cnt_last) begin
          w_cnt_nxt   = COOL_FRAMES;
          w_state_nxt = COOLDOWN;
        end else if (bus.frame_tick) begin
          w_cnt_nxt = sat_dec(r_cnt);
        end
      end
      COOLDOWN: begin
        if (bus.frame_tick) w_cnt_nxt = sat_dec(r_cnt);
        if (w_cnt_last)     w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_page = 4'd0;
    case (r_state)
      TALK:    w_page = prompt_page(r_tile_q);
      RESULT:  w_page = r_res_page;
      default: w_page = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key_p1   <= 4'd0;
      r_rst_p1   <= 1'b1;
      r_tile_q   <= 4'd0;
      r_res_page <= 4'd0;
      r_cnt      <= 8'd0;
      r_item     <= 1'b0;
      r_item2    <= 1'b0;
      r_door     <= 1'b0;
      r_page_sel <= 4'd0;
      r_busy     <= 1'b0;
      r_item_o   <= 1'b0;
      r_item2_o  <= 1'b0;
      r_door_o   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_key_p1   <= bus.key;
      r_rst_p1   <= 1'b0;
      r_tile_q   <= w_tile_nxt;
      r_res_page <= w_res_nxt;
      r_cnt      <= w_cnt_nxt;
      r_item     <= r_item  | w_set_item;
      r_item2    <= r_item2 | w_set_item2;
      r_door     <= r_door  | w_set_door;
      r_page_sel <= w_page;
      r_busy     <= (r_state != IDLE);
      r_item_o   <= r_item;
      r_item2_o  <= r_item2;
      r_door_o   <= r_door;
    end
  end

  assign bus.page_sel = r_page_sel;
  assign bus.busy     = r_busy;
  assign bus.item     = r_item_o;
  assign bus.item2    = r_item2_o;
  assign bus.door     = r_door_o;

endmodule

// File: doc/game_dialog_ctrl.md
GAME_DIALOG_CTRL -- requirements
Module: game_dialog_ctrl

Interface
REQ-001 SHALL have parameter KEY_ACCEPT, default 4'h1, meaning the key code that accepts or confirms a dialog.
REQ-002 SHALL have parameter HOLD_FRAMES, width 8, default 8'd120, meaning the number of frames a result page is shown.
REQ-003 SHALL have parameter COOL_FRAMES, width 8, default 8'd30, meaning the number of frames of blank dialog after a result.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port key, input, 4 bits: current keyboard code, 0 when no key is pressed.
REQ-007 SHALL have port current_pix, input, 4 bits: map tile code under the player.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-cycle pulse once per frame.
REQ-009 SHALL have port page_sel, output, 4 bits: text page index for the dialog renderer.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have ports item, item2 and door, outputs, 1 bit each: sticky game-progress flags.

Function
REQ-012 SHALL register all outputs, so that they update 1 cycle after the state or flag change that causes them.
REQ-013 SHALL generate accept as a 1-cycle pulse on the cycle when key==KEY_ACCEPT and the key register from the previous cycle was not KEY_ACCEPT; holding the key SHALL give exactly one pulse.
REQ-014 SHALL treat tile codes as follows:
- 2: NPC1
- 3: NPC2, item giver
- 4: door
- 6: chest
- any other code: no interaction
REQ-015 SHALL implement the states IDLE, TALK, RESULT and COOLDOWN.
REQ-016 In IDLE:
- page_sel=0.
- If current_pix is in {2,3,4,6}: latch it into tile_q and go to TALK.
REQ-017 In TALK, page_sel SHALL be the prompt page for tile_q: 2->1, 3->2, 4->3, 6->4.
REQ-018 In TALK, if current_pix!=tile_q: go to IDLE with no flag change; this SHALL take priority over an accept pulse in the same cycle.
REQ-019 In TALK, on accept, the next step SHALL depend on tile_q:
- 2: result page 5.
- 3: set item, result page 6; repeat visits SHALL show page 6 again with no other effect.
- 4: if item=1, set door, result page 7; else result page 8 (locked).
- 6: if item=1, set item2, result page 9; else result page 8.
- In all cases: load the frame counter with HOLD_FRAMES and go to RESULT.
REQ-020 In RESULT:
- page_sel holds the result page.
- The counter decrements on each frame_tick.
- Go to COOLDOWN when the counter reaches 0 on a tick, or on accept, whichever comes first; both in the same cycle SHALL give a single transition.
- Leaving the tile SHALL NOT abort RESULT.
REQ-021 On entry to COOLDOWN, the counter SHALL be loaded with COOL_FRAMES.
REQ-022 In COOLDOWN:
- page_sel=0 and accept is ignored.
- The counter decrements on frame_tick.
- At 0, go to IDLE.
REQ-023 Flag rules for item, item2 and door:
- Set only as given in REQ-019.
- Never cleared except by rst.
- Setting a flag that is already set SHALL be a no-op.
REQ-024 The counter SHALL saturate at 0 and never wrap.
- HOLD_FRAMES=0 or COOL_FRAMES=0 SHALL exit on the next frame_tick.
REQ-025 A frame_tick asserted while the counter is being loaded SHALL NOT decrement it in that cycle.
REQ-026 An accept that occurs in IDLE SHALL be discarded and SHALL NOT carry over into TALK.

Reset
REQ-027 When rst=1 on a clock edge, the block SHALL:
- set state to IDLE;
- clear tile_q, counter and the key register;
- drive page_sel=0, busy=0, item=0, item2=0, door=0 on the following cycle.
REQ-028 A reset asserted mid-dialog, including during RESULT or COOLDOWN, SHALL abort immediately and clear all flags.
REQ-029 A key held through the release of reset SHALL NOT produce an accept pulse.

Verification
REQ-030 Door while locked:
- Stimulus: current_pix=4, then key=1 for 3 cycles.
- Response: page_sel=3, then 8; door=0; exactly one accept.
REQ-031 Item then door:
- Stimulus: tile 3 with accept, wait through HOLD and COOL frames, then tile 4 with accept.
- Response: item=1 after the first accept; page_sel=7 and door=1 after the second; busy=0 after cooldown.
REQ-032 Walk-off priority:
- Stimulus: in TALK on tile 6 with item=1, current_pix changes to 0 in the same cycle as the accept.
- Response: state IDLE, item2=0, page_sel=0.
REQ-033 Timeout:
- Stimulus: HOLD_FRAMES=2 in RESULT, no key; frame_tick pulses.
- Response: COOLDOWN after the 2nd tick, IDLE after COOL_FRAMES ticks.
- Also check an accept coinciding with the final tick: a single transition.
REQ-034 Reset mid-RESULT:
- Stimulus: with item=1, door=1, assert rst for 1 cycle.
- Response: all outputs 0 on the next cycle; key held at 1 through reset produces no accept.
